// File: rtl/except_ctrl_pkg.sv
// except_ctrl_pkg
// Shared constants for the exception controller slice:
//   - CP0 Cause.ExcCode values driven on excepttype_o
//   - bit positions inside the MEM-stage exception flag vector
//   - FSM state encodings (plain constants so older code can reuse them)
//   - default redirect vector for exceptions and interrupts
package except_ctrl_pkg;

    localparam logic [31:0] EXC_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
    localparam logic [31:0] EXC_ADES = 32'h0000_0005;
    localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
    localparam logic [31:0] EXC_BP   = 32'h0000_0009;
    localparam logic [31:0] EXC_RI   = 32'h0000_000a;
    localparam logic [31:0] EXC_OV   = 32'h0000_000c;
    localparam logic [31:0] EXC_TR   = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET = 32'h0000_000e;

    localparam int EXC_NUM      = 9;
    localparam int EXCB_ADEL_IF = 0;
    localparam int EXCB_RI      = 1;
    localparam int EXCB_OV      = 2;
    localparam int EXCB_TRAP    = 3;
    localparam int EXCB_SYSCALL = 4;
    localparam int EXCB_BREAK   = 5;
    localparam int EXCB_ADEL    = 6;
    localparam int EXCB_ADES    = 7;
    localparam int EXCB_ERET    = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FIRE = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

endpackage

// File: rtl/except_prio_enc.sv
// except_prio_enc
// Combinational priority encoder for the exception controller. Picks the
// single highest-priority event among the interrupt request and the MEM
// stage exception flags and reports its Cause code and BadVAddr value.
// Ports:
//   int_req        in   interrupt pending or requested this cycle
//   mem_exc        in   MEM-stage exception flags (bit order from the package)
//   mem_bad_vaddr  in   data address of the MEM load/store
//   mem_pc         in   PC of the MEM instruction
//   hit            out  some event is present
//   code           out  ExcCode of the winning event, 0 when none
//   bad_vaddr      out  BadVAddr for the winning event, 0 when not an address error
module except_prio_enc
    import except_ctrl_pkg::*;
(
    input  logic               int_req,
    input  logic [EXC_NUM-1:0] mem_exc,
    input  logic [31:0]        mem_bad_vaddr,
    input  logic [31:0]        mem_pc,
    output logic               hit,
    output logic [31:0]        code,
    output logic [31:0]        bad_vaddr
);

    // Fixed priority chain. An instruction-fetch address error reports the
    // fetch PC as the bad address; data address errors report the data address.
    always_comb begin
        hit       = 1'b1;
        code      = '0;
        bad_vaddr = '0;
        if (int_req) begin
            code = EXC_INT;
        end else if (mem_exc[EXCB_ADEL_IF]) begin
            code      = EXC_ADEL;
            bad_vaddr = mem_pc;
        end else if (mem_exc[EXCB_RI]) begin
            code = EXC_RI;
        end else if (mem_exc[EXCB_OV]) begin
            code = EXC_OV;
        end else if (mem_exc[EXCB_TRAP]) begin
            code = EXC_TR;
        end else if (mem_exc[EXCB_SYSCALL]) begin
            code = EXC_SYS;
        end else if (mem_exc[EXCB_BREAK]) begin
            code = EXC_BP;
        end else if (mem_exc[EXCB_ADEL]) begin
            code      = EXC_ADEL;
            bad_vaddr = mem_bad_vaddr;
        end else if (mem_exc[EXCB_ADES]) begin
            code      = EXC_ADES;
            bad_vaddr = mem_bad_vaddr;
        end else if (mem_exc[EXCB_ERET]) begin
            code = EXC_ERET;
        end else begin
            hit = 1'b0;
        end
    end

endmodule

// File: rtl/except_ctrl.sv
// except_ctrl
// Producer side of the CP0 exception interface. Collects MEM-stage exception
// flags and pending interrupts, arbitrates them, reports the winner to CP0
// one cycle later together with a one-cycle pipeline flush and redirect PC,
// then ignores new MEM exceptions while the pipeline refills.
// Optional build macro: EXCEPT_CTRL_COUNT_EN enables the taken-event counter
// on exc_count_o (otherwise the output is tied to 0).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   stall               pipeline stall vector, bit 4 holds the MEM stage
//   mem_valid           MEM stage holds a real instruction
//   mem_pc              PC of the MEM instruction
//   mem_in_delayslot    MEM instruction sits in a branch delay slot
//   mem_exc             MEM exception flags
//   mem_bad_vaddr       data address for load/store address errors
//   cp0_status/cause/epc  bypassed CP0 registers
//   cancel_o            kill MEM writeback/store this cycle (combinational)
//   excepttype_o        ExcCode to CP0, 0 when nothing is taken
//   pc_o                faulting PC to CP0
//   bad_vaddr_o         BadVAddr to CP0
//   is_in_delayslot_o   delay-slot flag to CP0
//   flush_o             one-cycle pipeline flush
//   new_pc_o            redirect target, valid while flush_o is high
//   exc_count_o         count of taken non-ERET events
module except_ctrl
    import except_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEFAULT,
    parameter int          HOLD_CYCLES = 2,
    parameter int          STALL_W     = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               mem_valid,
    input  logic [31:0]        mem_pc,
    input  logic               mem_in_delayslot,
    input  logic [EXC_NUM-1:0] mem_exc,
    input  logic [31:0]        mem_bad_vaddr,
    input  logic [31:0]        cp0_status,
    input  logic [31:0]        cp0_cause,
    input  logic [31:0]        cp0_epc,
    output logic               cancel_o,
    output logic [31:0]        excepttype_o,
    output logic [31:0]        pc_o,
    output logic [31:0]        bad_vaddr_o,
    output logic               is_in_delayslot_o,
    output logic               flush_o,
    output logic [31:0]        new_pc_o,
    output logic [31:0]        exc_count_o
);

    localparam int HOLD_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);

    logic [1:0]        state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              int_pend_q, int_pend_d;
    logic [31:0]       excepttype_q, excepttype_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       bad_vaddr_q, bad_vaddr_d;
    logic              in_ds_q, in_ds_d;
    logic              flush_q, flush_d;
    logic [31:0]       new_pc_q, new_pc_d;

    logic              int_req;
    logic              enc_hit;
    logic [31:0]       enc_code;
    logic [31:0]       enc_bad_vaddr;
    logic              accept;
    logic              unused_inputs;

    // Interrupts are enabled when IE=1 and EXL=0 and some unmasked IP bit is set.
    assign int_req = cp0_status[0] & ~cp0_status[1]
                   & (|(cp0_cause[15:8] & cp0_status[15:8]));

    // Only some Status/Cause/stall bits matter here.
    assign unused_inputs = ^{stall, cp0_status, cp0_cause};

    except_prio_enc u_prio (
        .int_req       (int_pend_q | int_req),
        .mem_exc       (mem_exc),
        .mem_bad_vaddr (mem_bad_vaddr),
        .mem_pc        (mem_pc),
        .hit           (enc_hit),
        .code          (enc_code),
        .bad_vaddr     (enc_bad_vaddr)
    );

    // An event is taken only on a real, unstalled instruction while idle; a
    // stalled or bubbled candidate is simply re-evaluated next cycle.
    assign accept   = ~rst & (state_q == ST_IDLE) & mem_valid & ~stall[4] & enc_hit;
    assign cancel_o = accept;

    // FSM: FIRE is the cycle the flush is visible, HOLD masks MEM exceptions
    // while the redirected pipeline refills.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_FIRE;
                end
            end
            ST_FIRE: begin
                if (HOLD_CYCLES == 0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = HOLD_W'(HOLD_CYCLES);
                end
            end
            ST_HOLD: begin
                hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                if (hold_cnt_q == HOLD_W'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                hold_cnt_d = '0;
            end
        endcase
    end

    // While idle the pending flag follows the request and clears once the
    // interrupt is taken; while busy it stays latched until we can take it.
    always_comb begin
        if (state_q == ST_IDLE) begin
            int_pend_d = int_req & ~(accept & (enc_code == EXC_INT));
        end else begin
            int_pend_d = int_pend_q | int_req;
        end
    end

    // CP0-facing outputs: code and flush pulse for one cycle, the address
    // fields keep their last value for CP0/debug visibility.
    always_comb begin
        excepttype_d = '0;
        flush_d      = 1'b0;
        pc_d         = pc_q;
        bad_vaddr_d  = bad_vaddr_q;
        in_ds_d      = in_ds_q;
        new_pc_d     = new_pc_q;
        if (accept) begin
            excepttype_d = enc_code;
            flush_d      = 1'b1;
            pc_d         = mem_pc;
            bad_vaddr_d  = enc_bad_vaddr;
            in_ds_d      = mem_in_delayslot;
            new_pc_d     = (enc_code == EXC_ERET) ? cp0_epc : EXC_VECTOR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            hold_cnt_q   <= '0;
            int_pend_q   <= 1'b0;
            excepttype_q <= '0;
            flush_q      <= 1'b0;
            pc_q         <= '0;
            bad_vaddr_q  <= '0;
            in_ds_q      <= 1'b0;
            new_pc_q     <= '0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            int_pend_q   <= int_pend_d;
            excepttype_q <= excepttype_d;
            flush_q      <= flush_d;
            pc_q         <= pc_d;
            bad_vaddr_q  <= bad_vaddr_d;
            in_ds_q      <= in_ds_d;
            new_pc_q     <= new_pc_d;
        end
    end

    assign excepttype_o      = excepttype_q;
    assign flush_o           = flush_q;
    assign pc_o              = pc_q;
    assign bad_vaddr_o       = bad_vaddr_q;
    assign is_in_delayslot_o = in_ds_q;
    assign new_pc_o          = new_pc_q;

`ifdef EXCEPT_CTRL_COUNT_EN
    logic [31:0] exc_count_q, exc_count_d;

    // ERET is a return, not an exception, so it does not count.
    always_comb begin
        exc_count_d = exc_count_q;
        if ((state_q == ST_FIRE) && (excepttype_q != EXC_ERET)) begin
            exc_count_d = exc_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exc_count_q <= '0;
        end else begin
            exc_count_q <= exc_count_d;
        end
    end

    assign exc_count_o = exc_count_q;
`else
    assign exc_count_o = '0;
`endif

endmodule

// File: tb/tb_except_ctrl.sv
// tb_except_ctrl
// Self-checking bench for except_ctrl: directed scenarios followed by a
// randomized run compared cycle by cycle against a timeline-level model.
module tb_except_ctrl;

    localparam int          HOLD = 2;
    localparam logic [31:0] VEC  = 32'hBFC00380;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic        mem_in_delayslot;
    logic [8:0]  mem_exc;
    logic [31:0] mem_bad_vaddr;
    logic [31:0] cp0_status;
    logic [31:0] cp0_cause;
    logic [31:0] cp0_epc;
    logic        cancel_o;
    logic [31:0] excepttype_o;
    logic [31:0] pc_o;
    logic [31:0] bad_vaddr_o;
    logic        is_in_delayslot_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic [31:0] exc_count_o;

    except_ctrl #(.EXC_VECTOR(VEC), .HOLD_CYCLES(HOLD), .STALL_W(6)) dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .mem_valid         (mem_valid),
        .mem_pc            (mem_pc),
        .mem_in_delayslot  (mem_in_delayslot),
        .mem_exc           (mem_exc),
        .mem_bad_vaddr     (mem_bad_vaddr),
        .cp0_status        (cp0_status),
        .cp0_cause         (cp0_cause),
        .cp0_epc           (cp0_epc),
        .cancel_o          (cancel_o),
        .excepttype_o      (excepttype_o),
        .pc_o              (pc_o),
        .bad_vaddr_o       (bad_vaddr_o),
        .is_in_delayslot_o (is_in_delayslot_o),
        .flush_o           (flush_o),
        .new_pc_o          (new_pc_o),
        .exc_count_o       (exc_count_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a timeline of when the controller may next accept an
    // event, plus the values CP0 should see after each clock edge.
    int          cyc = 0;
    int          next_ok = 0;
    bit          m_pend = 1'b0;
    bit          prev_inc = 1'b0;
    logic [31:0] e_type = '0, e_pc = '0, e_bad = '0, e_newpc = '0, e_count = '0;
    logic        e_ds = 1'b0, e_flush = 1'b0, exp_cancel = 1'b0, obs_cancel = 1'b0, was_rst = 1'b0;

    // Priority slot 0 is the interrupt, slot k is mem_exc[k-1].
    function automatic logic [31:0] code_of(int i);
        case (i)
            0: return 32'h01;
            1: return 32'h04;
            2: return 32'h0a;
            3: return 32'h0c;
            4: return 32'h0d;
            5: return 32'h08;
            6: return 32'h09;
            7: return 32'h04;
            8: return 32'h05;
            default: return 32'h0e;
        endcase
    endfunction

    task automatic model_eval();
        bit ireq, idle, found, acc, flag;
        int sel;
        if (rst) begin
            e_type = '0; e_pc = '0; e_bad = '0; e_newpc = '0; e_count = '0;
            e_ds = 1'b0; e_flush = 1'b0; exp_cancel = 1'b0;
            m_pend = 1'b0; prev_inc = 1'b0;
            next_ok = cyc + 1;
            cyc++;
            return;
        end
        ireq  = cp0_status[0] && !cp0_status[1] && ((cp0_cause[15:8] & cp0_status[15:8]) != 0);
        idle  = (cyc >= next_ok);
        found = 1'b0;
        sel   = 0;
        for (int i = 0; i < 10; i++) begin
            flag = (i == 0) ? (m_pend || ireq) : mem_exc[i-1];
            if (!found && flag) begin
                found = 1'b1;
                sel   = i;
            end
        end
        acc = idle && mem_valid && !stall[4] && found;
        exp_cancel = acc;
`ifdef EXCEPT_CTRL_COUNT_EN
        if (prev_inc) e_count = e_count + 32'd1;
`endif
        prev_inc = acc && (sel != 9);
        e_flush  = acc;
        if (acc) begin
            e_type  = code_of(sel);
            e_pc    = mem_pc;
            e_ds    = mem_in_delayslot;
            e_bad   = (sel == 1) ? mem_pc : ((sel == 7 || sel == 8) ? mem_bad_vaddr : 32'h0);
            e_newpc = (sel == 9) ? cp0_epc : VEC;
            next_ok = cyc + 2 + HOLD;
        end else begin
            e_type = '0;
        end
        m_pend = idle ? (ireq && !(acc && sel == 0)) : (m_pend || ireq);
        cyc++;
    endtask

    // One clock: sample the combinational cancel mid-cycle, advance the
    // model, and return just after the edge with inputs free to change.
    task automatic tick();
        @(negedge clk);
        obs_cancel = cancel_o;
        was_rst    = rst;
        model_eval();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        stall = '0; mem_valid = 1'b0; mem_pc = '0; mem_in_delayslot = 1'b0;
        mem_exc = '0; mem_bad_vaddr = '0; cp0_status = '0; cp0_cause = '0; cp0_epc = '0;
    endtask

    task automatic drive_exc(input logic [31:0] pc, input int bit_idx);
        quiet();
        mem_valid = 1'b1;
        mem_pc    = pc;
        mem_exc[bit_idx] = 1'b1;
    endtask

    task automatic test_reset();
        quiet();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++; if (excepttype_o !== 32'h0) begin n_err++; $display("[TB] FAIL reset_type: got %h expected 0", excepttype_o); end
        n_cmp++; if (pc_o !== 32'h0) begin n_err++; $display("[TB] FAIL reset_pc: got %h expected 0", pc_o); end
        n_cmp++; if (bad_vaddr_o !== 32'h0) begin n_err++; $display("[TB] FAIL reset_bad: got %h expected 0", bad_vaddr_o); end
        n_cmp++; if (is_in_delayslot_o !== 1'b0) begin n_err++; $display("[TB] FAIL reset_ds: got %b expected 0", is_in_delayslot_o); end
        n_cmp++; if (flush_o !== 1'b0) begin n_err++; $display("[TB] FAIL reset_flush: got %b expected 0", flush_o); end
        n_cmp++; if (new_pc_o !== 32'h0) begin n_err++; $display("[TB] FAIL reset_newpc: got %h expected 0", new_pc_o); end
        n_cmp++; if (exc_count_o !== 32'h0) begin n_err++; $display("[TB] FAIL reset_count: got %h expected 0", exc_count_o); end
        rst = 1'b0;
        tick();
        n_cmp++; if (obs_cancel !== 1'b0) begin n_err++; $display("[TB] FAIL reset_cancel: got %b expected 0", obs_cancel); end
    endtask

    task automatic test_syscall();
        drive_exc(32'hBFC00100, 4);
        tick();
        quiet();
        n_cmp++; if (obs_cancel !== 1'b1) begin n_err++; $display("[TB] FAIL sys_cancel: got %b expected 1", obs_cancel); end
        n_cmp++; if (excepttype_o !== 32'h08) begin n_err++; $display("[TB] FAIL sys_type: got %h expected 08", excepttype_o); end
        n_cmp++; if (pc_o !== 32'hBFC00100) begin n_err++; $display("[TB] FAIL sys_pc: got %h expected bfc00100", pc_o); end
        n_cmp++; if (flush_o !== 1'b1) begin n_err++; $display("[TB] FAIL sys_flush: got %b expected 1", flush_o); end
        n_cmp++; if (new_pc_o !== 32'hBFC00380) begin n_err++; $display("[TB] FAIL sys_newpc: got %h expected bfc00380", new_pc_o); end
        n_cmp++; if (bad_vaddr_o !== 32'h0) begin n_err++; $display("[TB] FAIL sys_bad: got %h expected 0", bad_vaddr_o); end
        tick();
        n_cmp++; if (flush_o !== 1'b0) begin n_err++; $display("[TB] FAIL sys_flush_n2: got %b expected 0", flush_o); end
        n_cmp++; if (excepttype_o !== 32'h0) begin n_err++; $display("[TB] FAIL sys_type_n2: got %h expected 0", excepttype_o); end
        n_cmp++; if (pc_o !== 32'hBFC00100) begin n_err++; $display("[TB] FAIL sys_pc_hold: got %h expected bfc00100", pc_o); end
        n_cmp++; if (new_pc_o !== 32'hBFC00380) begin n_err++; $display("[TB] FAIL sys_newpc_hold: got %h expected bfc00380", new_pc_o); end
        repeat (4) tick();
    endtask

    task automatic test_eret();
        logic [31:0] count_before;
        count_before = e_count;
        drive_exc(32'h80000400, 8);
        cp0_epc = 32'h80001234;
        tick();
        quiet();
        cp0_epc = 32'hDEAD0000;
        n_cmp++; if (excepttype_o !== 32'h0e) begin n_err++; $display("[TB] FAIL eret_type: got %h expected 0e", excepttype_o); end
        n_cmp++; if (new_pc_o !== 32'h80001234) begin n_err++; $display("[TB] FAIL eret_newpc: got %h expected 80001234", new_pc_o); end
        tick();
        tick();
        n_cmp++; if (exc_count_o !== count_before) begin n_err++; $display("[TB] FAIL eret_count: got %h expected %h", exc_count_o, count_before); end
        repeat (3) tick();
    endtask

    task automatic test_interrupt_bubble();
        quiet();
        cp0_status = 32'h0000FF01;
        cp0_cause  = 32'h00000400;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_cmp++; if (obs_cancel !== 1'b0) begin n_err++; $display("[TB] FAIL int_bubble_cancel: got %b expected 0", obs_cancel); end
            n_cmp++; if (flush_o !== 1'b0) begin n_err++; $display("[TB] FAIL int_bubble_flush: got %b expected 0", flush_o); end
        end
        mem_valid = 1'b1;
        mem_pc = 32'h80000010;
        mem_in_delayslot = 1'b1;
        tick();
        quiet();
        n_cmp++; if (obs_cancel !== 1'b1) begin n_err++; $display("[TB] FAIL int_cancel: got %b expected 1", obs_cancel); end
        n_cmp++; if (excepttype_o !== 32'h01) begin n_err++; $display("[TB] FAIL int_type: got %h expected 01", excepttype_o); end
        n_cmp++; if (is_in_delayslot_o !== 1'b1) begin n_err++; $display("[TB] FAIL int_ds: got %b expected 1", is_in_delayslot_o); end
        n_cmp++; if (pc_o !== 32'h80000010) begin n_err++; $display("[TB] FAIL int_pc: got %h expected 80000010", pc_o); end
        repeat (4) tick();
    endtask

    task automatic test_priority();
        quiet();
        mem_valid = 1'b1;
        mem_pc = 32'h80000020;
        mem_exc = 9'b0_1000_0110;
        mem_bad_vaddr = 32'h3;
        tick();
        quiet();
        n_cmp++; if (excepttype_o !== 32'h0a) begin n_err++; $display("[TB] FAIL prio_type: got %h expected 0a", excepttype_o); end
        n_cmp++; if (bad_vaddr_o !== 32'h0) begin n_err++; $display("[TB] FAIL prio_bad: got %h expected 0", bad_vaddr_o); end
        repeat (4) tick();
        drive_exc(32'h80000024, 7);
        mem_bad_vaddr = 32'h3;
        tick();
        quiet();
        n_cmp++; if (excepttype_o !== 32'h05) begin n_err++; $display("[TB] FAIL ades_type: got %h expected 05", excepttype_o); end
        n_cmp++; if (bad_vaddr_o !== 32'h3) begin n_err++; $display("[TB] FAIL ades_bad: got %h expected 3", bad_vaddr_o); end
        repeat (4) tick();
    endtask

    task automatic test_stall_and_hold();
        drive_exc(32'h80000100, 4);
        stall = 6'b010000;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if (obs_cancel !== 1'b0) begin n_err++; $display("[TB] FAIL stall_cancel: got %b expected 0", obs_cancel); end
            n_cmp++; if (flush_o !== 1'b0) begin n_err++; $display("[TB] FAIL stall_flush: got %b expected 0", flush_o); end
        end
        stall = '0;
        tick();
        n_cmp++; if (obs_cancel !== 1'b1) begin n_err++; $display("[TB] FAIL release_cancel: got %b expected 1", obs_cancel); end
        n_cmp++; if (flush_o !== 1'b1) begin n_err++; $display("[TB] FAIL release_flush: got %b expected 1", flush_o); end
        // The same exception stays on the MEM inputs through FIRE and HOLD.
        for (int k = 0; k < 1 + HOLD; k++) begin
            tick();
            n_cmp++; if (obs_cancel !== 1'b0) begin n_err++; $display("[TB] FAIL hold_cancel%0d: got %b expected 0", k, obs_cancel); end
            n_cmp++; if (flush_o !== 1'b0) begin n_err++; $display("[TB] FAIL hold_flush%0d: got %b expected 0", k, flush_o); end
        end
        tick();
        n_cmp++; if (obs_cancel !== 1'b1) begin n_err++; $display("[TB] FAIL after_hold_cancel: got %b expected 1", obs_cancel); end
        quiet();
        repeat (4) tick();
    endtask

    task automatic test_reset_during_fire();
        drive_exc(32'h80000200, 5);
        tick();
        n_cmp++; if (flush_o !== 1'b1) begin n_err++; $display("[TB] FAIL rf_flush_fire: got %b expected 1", flush_o); end
        quiet();
        rst = 1'b1;
        tick();
        n_cmp++; if (flush_o !== 1'b0) begin n_err++; $display("[TB] FAIL rf_flush: got %b expected 0", flush_o); end
        n_cmp++; if ({excepttype_o, pc_o, bad_vaddr_o, new_pc_o} !== 128'h0) begin n_err++; $display("[TB] FAIL rf_outputs: got %h %h %h %h expected all 0", excepttype_o, pc_o, bad_vaddr_o, new_pc_o); end
        n_cmp++; if (exc_count_o !== 32'h0) begin n_err++; $display("[TB] FAIL rf_count: got %h expected 0", exc_count_o); end
        rst = 1'b0;
        drive_exc(32'h80000300, 4);
        tick();
        quiet();
        n_cmp++; if (obs_cancel !== 1'b1) begin n_err++; $display("[TB] FAIL rf_idle_cancel: got %b expected 1", obs_cancel); end
        n_cmp++; if (excepttype_o !== 32'h08) begin n_err++; $display("[TB] FAIL rf_idle_type: got %h expected 08", excepttype_o); end
        repeat (4) tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            mem_valid = ($urandom_range(9) < 8);
            stall = 6'($urandom);
            stall[4] = ($urandom_range(4) == 0);
            mem_pc = $urandom;
            mem_in_delayslot = 1'($urandom);
            mem_bad_vaddr = $urandom;
            cp0_epc = $urandom;
            mem_exc = '0;
            for (int b = 0; b < 9; b++) if ($urandom_range(11) == 0) mem_exc[b] = 1'b1;
            cp0_status = $urandom;
            cp0_status[1] = ($urandom_range(3) == 0);
            cp0_cause = $urandom & 32'hFFFF00FF;
            if ($urandom_range(5) == 0) cp0_cause[8 + $urandom_range(7)] = 1'b1;
            tick();
            if (!was_rst) begin
                n_cmp++; if (obs_cancel !== exp_cancel) begin n_err++; $display("[TB] FAIL rnd_cancel@%0d: got %b expected %b", n, obs_cancel, exp_cancel); end
            end
            n_cmp++; if (excepttype_o !== e_type) begin n_err++; $display("[TB] FAIL rnd_type@%0d: got %h expected %h", n, excepttype_o, e_type); end
            n_cmp++; if (flush_o !== e_flush) begin n_err++; $display("[TB] FAIL rnd_flush@%0d: got %b expected %b", n, flush_o, e_flush); end
            n_cmp++; if (pc_o !== e_pc) begin n_err++; $display("[TB] FAIL rnd_pc@%0d: got %h expected %h", n, pc_o, e_pc); end
            n_cmp++; if (bad_vaddr_o !== e_bad) begin n_err++; $display("[TB] FAIL rnd_bad@%0d: got %h expected %h", n, bad_vaddr_o, e_bad); end
            n_cmp++; if (is_in_delayslot_o !== e_ds) begin n_err++; $display("[TB] FAIL rnd_ds@%0d: got %b expected %b", n, is_in_delayslot_o, e_ds); end
            n_cmp++; if (new_pc_o !== e_newpc) begin n_err++; $display("[TB] FAIL rnd_newpc@%0d: got %h expected %h", n, new_pc_o, e_newpc); end
            n_cmp++; if (exc_count_o !== e_count) begin n_err++; $display("[TB] FAIL rnd_count@%0d: got %h expected %h", n, exc_count_o, e_count); end
        end
        quiet();
    endtask

    initial begin
        quiet();
        rst = 1'b1;
        $display("[TB] starting except_ctrl bench");
        test_reset();
        test_syscall();
        test_eret();
        test_interrupt_bubble();
        test_priority();
        test_stall_and_hold();
        test_reset_during_fire();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
